// File: rtl/initfc_dllp_tx.sv
// Transmit-side InitFC1/InitFC2 sequencer for one virtual channel: offers P/NP/Cpl
// InitFC DLLPs to the arbiter, tracks FI1/FI2 and reports FC-init completion.
module initfc_dllp_tx #(
    parameter logic [2:0]  VC            = 3'd0,
    parameter logic [1:0]  HDR_SCALE     = 2'b00,
    parameter logic [1:0]  DATA_SCALE    = 2'b00,
    parameter int unsigned RESEND_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        link_up,
    input  logic [7:0]  p_hdr_fc,
    input  logic [7:0]  np_hdr_fc,
    input  logic [7:0]  cpl_hdr_fc,
    input  logic [11:0] p_data_fc,
    input  logic [11:0] np_data_fc,
    input  logic [11:0] cpl_data_fc,
    output logic        dllp_valid,
    input  logic        dllp_ready,
    output logic [31:0] dllp_data,
    input  logic        rx_initfc_valid,
    input  logic        rx_initfc_phase,
    input  logic [1:0]  rx_initfc_type,
    input  logic [2:0]  rx_initfc_vc,
    input  logic        rx_updatefc_valid,
    output logic        fi1_done,
    output logic        fc_init_done
);
    localparam int unsigned   CW       = (RESEND_CYCLES > 1) ? $clog2(RESEND_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(RESEND_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT1_SEND,
        S_INIT1_WAIT,
        S_INIT2_SEND,
        S_INIT2_WAIT,
        S_DONE
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    flags_q, flags_d, flags_nx, rx_bit;
    logic          fi2_q, fi2_d, fi2_nx;
    logic          fi1_done_q, done_q, done_d;
    logic          valid_q, valid_d;
    logic [31:0]   data_q, data_d;
    logic [7:0]    p_hdr_q, np_hdr_q, cpl_hdr_q;
    logic [11:0]   p_data_q, np_data_q, cpl_data_q;
    logic          capture, load, clr, ld_phase, send_phase;
    logic [1:0]    ld_idx;
    logic [7:0]    ld_hdr;
    logic [11:0]   ld_dat;
    logic          rx_hit, accept, fi1_all, exit_ok;

    function automatic logic [31:0] fc_word(input logic [1:0] idx, input logic phase,
                                            input logic [7:0] hdr, input logic [11:0] dat);
        logic [2:0] t;
        case (idx)
            2'd0:    t = 3'b100;
            2'd1:    t = 3'b110;
            default: t = 3'b111;
        endcase
        return {t, phase, VC, HDR_SCALE, DATA_SCALE, hdr, 1'b0, dat};
    endfunction

    always_comb begin
        case (rx_initfc_type)
            2'b00:   rx_bit = 3'b001;
            2'b10:   rx_bit = 3'b010;
            2'b11:   rx_bit = 3'b100;
            default: rx_bit = 3'b000;
        endcase
    end

    // Flag updates from this cycle count toward exit decisions taken at this edge.
    assign rx_hit   = rx_initfc_valid && (rx_initfc_vc == VC) && (rx_initfc_type != 2'b01);
    assign flags_nx = flags_q | (rx_hit ? rx_bit : 3'b000);
    assign fi2_nx   = fi2_q | (rx_hit && rx_initfc_phase) | rx_updatefc_valid;
    assign fi1_all  = &flags_nx;
    assign accept   = valid_q && dllp_ready;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        valid_d    = valid_q;
        flags_d    = flags_nx;
        fi2_d      = fi2_nx;
        capture    = 1'b0;
        load       = 1'b0;
        clr        = 1'b0;
        ld_idx     = idx_q;
        ld_phase   = 1'b0;
        send_phase = (state_q == S_INIT2_SEND);
        exit_ok    = (state_q == S_INIT1_SEND || state_q == S_INIT1_WAIT) ? fi1_all : fi2_nx;
        if (!link_up) begin
            state_d = S_IDLE;
            idx_d   = '0;
            cnt_d   = '0;
            flags_d = '0;
            fi2_d   = 1'b0;
            valid_d = 1'b0;
            clr     = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_INIT1_SEND;
                    capture = 1'b1;
                end
                S_INIT1_SEND, S_INIT2_SEND: begin
                    if (!valid_q) begin
                        load     = 1'b1;
                        ld_phase = send_phase;
                        valid_d  = 1'b1;
                    end else if (accept) begin
                        if (idx_q != 2'd2) begin
                            idx_d    = idx_q + 2'd1;
                            load     = 1'b1;
                            ld_idx   = idx_q + 2'd1;
                            ld_phase = send_phase;
                        end else begin
                            idx_d = '0;
                            if (exit_ok && !send_phase) begin
                                state_d  = S_INIT2_SEND;
                                load     = 1'b1;
                                ld_idx   = 2'd0;
                                ld_phase = 1'b1;
                            end else if (exit_ok) begin
                                state_d = S_DONE;
                                valid_d = 1'b0;
                            end else begin
                                state_d = send_phase ? S_INIT2_WAIT : S_INIT1_WAIT;
                                valid_d = 1'b0;
                                cnt_d   = CNT_LOAD;
                            end
                        end
                    end
                end
                S_INIT1_WAIT, S_INIT2_WAIT: begin
                    if (exit_ok && state_q == S_INIT1_WAIT) begin
                        state_d  = S_INIT2_SEND;
                        load     = 1'b1;
                        ld_idx   = 2'd0;
                        ld_phase = 1'b1;
                        valid_d  = 1'b1;
                        cnt_d    = '0;
                    end else if (exit_ok) begin
                        state_d = S_DONE;
                        cnt_d   = '0;
                    end else if (cnt_q == '0) begin
                        state_d  = (state_q == S_INIT1_WAIT) ? S_INIT1_SEND : S_INIT2_SEND;
                        load     = 1'b1;
                        ld_idx   = 2'd0;
                        ld_phase = (state_q == S_INIT2_WAIT);
                        valid_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                S_DONE: valid_d = 1'b0;
                default: state_d = S_IDLE;
            endcase
        end
        done_d = (state_d == S_DONE);
    end

    always_comb begin
        case (ld_idx)
            2'd0: begin ld_hdr = p_hdr_q;   ld_dat = p_data_q;   end
            2'd1: begin ld_hdr = np_hdr_q;  ld_dat = np_data_q;  end
            default: begin ld_hdr = cpl_hdr_q; ld_dat = cpl_data_q; end
        endcase
        data_d = data_q;
        if (clr) begin
            data_d = '0;
        end else if (load) begin
            data_d = fc_word(ld_idx, ld_phase, ld_hdr, ld_dat);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            flags_q    <= '0;
            fi2_q      <= 1'b0;
            fi1_done_q <= 1'b0;
            done_q     <= 1'b0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            p_hdr_q    <= '0;
            np_hdr_q   <= '0;
            cpl_hdr_q  <= '0;
            p_data_q   <= '0;
            np_data_q  <= '0;
            cpl_data_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            flags_q    <= flags_d;
            fi2_q      <= fi2_d;
            fi1_done_q <= &flags_d;
            done_q     <= done_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            if (capture) begin
                p_hdr_q    <= p_hdr_fc;
                np_hdr_q   <= np_hdr_fc;
                cpl_hdr_q  <= cpl_hdr_fc;
                p_data_q   <= p_data_fc;
                np_data_q  <= np_data_fc;
                cpl_data_q <= cpl_data_fc;
            end
        end
    end

    assign dllp_valid   = valid_q;
    assign dllp_data    = data_q;
    assign fi1_done     = fi1_done_q;
    assign fc_init_done = done_q;
endmodule

// File: tb/tb_initfc_dllp_tx.sv
// Bench for initfc_dllp_tx: vector table, directed corner sequences and a
// randomized run checked every cycle against a transaction-level model.
module tb_initfc_dllp_tx;
    localparam logic [2:0]  VC  = 3'd0;
    localparam int unsigned RES = 1024;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        link_up;
    logic [7:0]  p_hdr_fc, np_hdr_fc, cpl_hdr_fc;
    logic [11:0] p_data_fc, np_data_fc, cpl_data_fc;
    logic        dllp_valid, dllp_ready;
    logic [31:0] dllp_data;
    logic        rx_initfc_valid, rx_initfc_phase;
    logic [1:0]  rx_initfc_type;
    logic [2:0]  rx_initfc_vc;
    logic        rx_updatefc_valid;
    logic        fi1_done, fc_init_done;

    always #5 clk = ~clk;

    initfc_dllp_tx #(
        .VC(VC), .HDR_SCALE(2'b00), .DATA_SCALE(2'b00), .RESEND_CYCLES(RES)
    ) dut (
        .clk(clk), .rst_n(rst_n), .link_up(link_up),
        .p_hdr_fc(p_hdr_fc), .np_hdr_fc(np_hdr_fc), .cpl_hdr_fc(cpl_hdr_fc),
        .p_data_fc(p_data_fc), .np_data_fc(np_data_fc), .cpl_data_fc(cpl_data_fc),
        .dllp_valid(dllp_valid), .dllp_ready(dllp_ready), .dllp_data(dllp_data),
        .rx_initfc_valid(rx_initfc_valid), .rx_initfc_phase(rx_initfc_phase),
        .rx_initfc_type(rx_initfc_type), .rx_initfc_vc(rx_initfc_vc),
        .rx_updatefc_valid(rx_updatefc_valid),
        .fi1_done(fi1_done), .fc_init_done(fc_init_done)
    );

    int unsigned n_chk = 0;
    int unsigned n_fail = 0;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk_word(input int t, input logic ph,
                                            input logic [7:0] h, input logic [11:0] d);
        logic [2:0] tc;
        tc = (t == 0) ? 3'b100 : (t == 1) ? 3'b110 : 3'b111;
        return {tc, ph, VC, 2'b00, 2'b00, h, 1'b0, d};
    endfunction

    // ---------------- reference model ----------------
    logic        m_valid, m_fi1, m_done, m_active, m_starting, m_fi2;
    logic [31:0] m_data;
    logic [2:0]  m_rcv;
    int          m_phase, m_pos;
    int unsigned m_idle;
    logic [7:0]  m_h [3];
    logic [11:0] m_d [3];

    task automatic model_reset();
        m_valid = 0; m_fi1 = 0; m_done = 0; m_active = 0; m_starting = 0; m_fi2 = 0;
        m_data = '0; m_rcv = '0; m_phase = 0; m_pos = 0; m_idle = 0;
    endtask

    task automatic offer(input int p);
        m_pos   = p;
        m_valid = 1'b1;
        m_data  = mk_word(p, m_phase == 2, m_h[p], m_d[p]);
    endtask

    task automatic advance();
        if (m_phase == 1) begin
            m_phase = 2;
            offer(0);
        end else begin
            m_done  = 1'b1;
            m_valid = 1'b0;
        end
    endtask

    task automatic model_step();
        logic hit, go;
        int t;
        if (!link_up) begin
            model_reset();
            return;
        end
        hit = rx_initfc_valid && (rx_initfc_vc == VC) && (rx_initfc_type != 2'b01);
        if (hit) begin
            t = (rx_initfc_type == 2'b00) ? 0 : (rx_initfc_type == 2'b10) ? 1 : 2;
            m_rcv[t] = 1'b1;
            if (rx_initfc_phase) m_fi2 = 1'b1;
        end
        if (rx_updatefc_valid) m_fi2 = 1'b1;
        m_fi1 = &m_rcv;
        go = (m_phase == 1) ? m_fi1 : m_fi2;
        if (!m_active) begin
            m_active = 1; m_starting = 1; m_phase = 1;
            m_h[0] = p_hdr_fc;  m_h[1] = np_hdr_fc;  m_h[2] = cpl_hdr_fc;
            m_d[0] = p_data_fc; m_d[1] = np_data_fc; m_d[2] = cpl_data_fc;
        end else if (m_done) begin
            m_valid = 1'b0;
        end else if (m_starting) begin
            m_starting = 0;
            offer(0);
        end else if (m_valid) begin
            if (dllp_ready) begin
                if (m_pos < 2) offer(m_pos + 1);
                else if (go) advance();
                else begin
                    m_valid = 1'b0;
                    m_idle  = 1;
                end
            end
        end else if (go) begin
            advance();
        end else if (m_idle == RES) begin
            offer(0);
        end else begin
            m_idle++;
        end
    endtask

    task automatic model_cmp();
        chk1("mdl_valid", dllp_valid, m_valid);
        if (m_valid) chk32("mdl_data", dllp_data, m_data);
        chk1("mdl_fi1", fi1_done, m_fi1);
        chk1("mdl_done", fc_init_done, m_done);
    endtask

    task automatic cycle();
        model_step();
        @(negedge clk);
        model_cmp();
    endtask

    task automatic set_rx(input logic v, input logic ph, input logic [1:0] ty, input logic [2:0] vc);
        rx_initfc_valid = v; rx_initfc_phase = ph; rx_initfc_type = ty; rx_initfc_vc = vc;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        link, rdy, rxv, rxph;
        logic [1:0]  rxty;
        logic [2:0]  rxvc;
        logic        upd;
        logic        ev;
        logic [31:0] ed;
        logic        ef, edn;
    } vec_t;

    localparam int NV = 18;
    vec_t tbl [NV];

    localparam logic [31:0] P1 = 32'h8004_0080, NP1 = 32'hC002_2222, C1 = 32'hE006_6444;
    localparam logic [31:0] P2 = 32'h9004_0080, NP2 = 32'hD002_2222, C2 = 32'hF006_6444;

    int unsigned gap;
    int          down_left;
    logic        quiet;

    initial begin
        tbl[0]  = '{1, 1, 0, 0, 2'b00, 3'd0, 0, 0, 32'h0, 0, 0};
        tbl[1]  = '{1, 1, 1, 0, 2'b00, 3'd0, 0, 1, P1,    0, 0};
        tbl[2]  = '{1, 1, 1, 0, 2'b10, 3'd0, 0, 1, NP1,   0, 0};
        tbl[3]  = '{1, 0, 1, 0, 2'b11, 3'd0, 0, 1, NP1,   1, 0};
        tbl[4]  = '{1, 0, 0, 0, 2'b00, 3'd0, 0, 1, NP1,   1, 0};
        tbl[5]  = '{1, 0, 0, 0, 2'b00, 3'd0, 0, 1, NP1,   1, 0};
        tbl[6]  = '{1, 0, 0, 0, 2'b00, 3'd0, 0, 1, NP1,   1, 0};
        tbl[7]  = '{1, 0, 0, 0, 2'b00, 3'd0, 0, 1, NP1,   1, 0};
        tbl[8]  = '{1, 1, 0, 0, 2'b00, 3'd0, 0, 1, C1,    1, 0};
        tbl[9]  = '{1, 1, 0, 0, 2'b00, 3'd0, 0, 1, P2,    1, 0};
        tbl[10] = '{1, 1, 0, 0, 2'b00, 3'd0, 0, 1, NP2,   1, 0};
        tbl[11] = '{1, 1, 0, 0, 2'b00, 3'd0, 0, 1, C2,    1, 0};
        tbl[12] = '{1, 1, 0, 0, 2'b00, 3'd0, 0, 0, 32'h0, 1, 0};
        tbl[13] = '{1, 1, 0, 0, 2'b00, 3'd0, 1, 0, 32'h0, 1, 1};
        tbl[14] = '{1, 1, 0, 0, 2'b00, 3'd0, 0, 0, 32'h0, 1, 1};
        tbl[15] = '{1, 1, 0, 0, 2'b00, 3'd0, 0, 0, 32'h0, 1, 1};
        tbl[16] = '{0, 1, 0, 0, 2'b00, 3'd0, 0, 0, 32'h0, 0, 0};
        tbl[17] = '{0, 1, 0, 0, 2'b00, 3'd0, 0, 0, 32'h0, 0, 0};

        rst_n = 1'b0; link_up = 1'b0; dllp_ready = 1'b0; rx_updatefc_valid = 1'b0;
        set_rx(0, 0, 2'b00, 3'd0);
        p_hdr_fc = 8'h20; p_data_fc = 12'h080;
        np_hdr_fc = 8'h11; np_data_fc = 12'h222;
        cpl_hdr_fc = 8'h33; cpl_data_fc = 12'h444;
        model_reset();
        repeat (2) @(negedge clk);
        chk1("rst_valid", dllp_valid, 1'b0);
        chk32("rst_data", dllp_data, 32'h0);
        chk1("rst_fi1", fi1_done, 1'b0);
        chk1("rst_done", fc_init_done, 1'b0);
        rst_n = 1'b1;
        cycle();

        for (int i = 0; i < NV; i++) begin
            link_up = tbl[i].link; dllp_ready = tbl[i].rdy;
            set_rx(tbl[i].rxv, tbl[i].rxph, tbl[i].rxty, tbl[i].rxvc);
            rx_updatefc_valid = tbl[i].upd;
            cycle();
            chk1($sformatf("vec%0d_valid", i), dllp_valid, tbl[i].ev);
            if (tbl[i].ev) chk32($sformatf("vec%0d_data", i), dllp_data, tbl[i].ed);
            chk1($sformatf("vec%0d_fi1", i), fi1_done, tbl[i].ef);
            chk1($sformatf("vec%0d_done", i), fc_init_done, tbl[i].edn);
        end
        set_rx(0, 0, 2'b00, 3'd0); rx_updatefc_valid = 1'b0;

        // Resend gap with rejected InitFCs (wrong VC / type 01) during it.
        link_up = 1'b1; dllp_ready = 1'b1;
        cycle();
        chk1("gap_first_idle", dllp_valid, 1'b0);
        cycle(); chk32("gap_p1", dllp_data, P1);
        cycle(); chk32("gap_np1", dllp_data, NP1);
        cycle(); chk32("gap_cpl1", dllp_data, C1);
        gap = 0;
        while (gap < 3000) begin
            if (gap == 10)      set_rx(1, 0, 2'b00, 3'd3);
            else if (gap == 20) set_rx(1, 0, 2'b01, 3'd0);
            else if (gap == 30) set_rx(1, 1, 2'b11, 3'd3);
            else                set_rx(0, 0, 2'b00, 3'd0);
            cycle();
            if (dllp_valid) break;
            gap++;
        end
        set_rx(0, 0, 2'b00, 3'd0);
        chk32("gap_len", gap, RES);
        chk32("gap_repeat_p1", dllp_data, P1);
        chk1("gap_fi1_clear", fi1_done, 1'b0);

        set_rx(1, 0, 2'b10, 3'd3); cycle(); chk32("bad_np1", dllp_data, NP1);
        set_rx(1, 0, 2'b01, 3'd0); cycle(); chk32("bad_cpl1", dllp_data, C1);
        set_rx(0, 0, 2'b00, 3'd0); cycle();
        chk1("bad_stays_init1", dllp_valid, 1'b0);
        chk1("bad_fi1", fi1_done, 1'b0);

        // Exit from INIT1_WAIT once all three types arrive.
        set_rx(1, 0, 2'b00, 3'd0); cycle(); chk1("wexit_wait_p", dllp_valid, 1'b0);
        set_rx(1, 0, 2'b10, 3'd0); cycle(); chk1("wexit_wait_np", dllp_valid, 1'b0);
        set_rx(1, 0, 2'b11, 3'd0); cycle();
        chk1("wexit_valid", dllp_valid, 1'b1);
        chk32("wexit_p2", dllp_data, P2);
        chk1("wexit_fi1", fi1_done, 1'b1);
        set_rx(0, 0, 2'b00, 3'd0);

        // Link drop with a pending word.
        dllp_ready = 1'b0; link_up = 1'b0;
        cycle();
        chk1("drop_valid", dllp_valid, 1'b0);
        chk1("drop_fi1", fi1_done, 1'b0);
        chk1("drop_done", fc_init_done, 1'b0);

        // InitFC2 received during INIT1: straight to DONE after the InitFC2 set.
        link_up = 1'b1; dllp_ready = 1'b1;
        cycle();
        set_rx(1, 1, 2'b00, 3'd0); cycle(); chk32("fi2_p1", dllp_data, P1);
        set_rx(1, 1, 2'b10, 3'd0); cycle(); chk32("fi2_np1", dllp_data, NP1);
        set_rx(1, 1, 2'b11, 3'd0); cycle(); chk32("fi2_cpl1", dllp_data, C1);
        set_rx(0, 0, 2'b00, 3'd0);
        cycle(); chk32("fi2_p2", dllp_data, P2);
        cycle(); chk32("fi2_np2", dllp_data, NP2);
        cycle(); chk32("fi2_cpl2", dllp_data, C2);
        cycle();
        chk1("fi2_done", fc_init_done, 1'b1);
        chk1("fi2_done_valid", dllp_valid, 1'b0);
        link_up = 1'b0;
        cycle();

        // Randomized run against the model.
        down_left = 0;
        for (int i = 0; i < 9000; i++) begin
            quiet = ((i / 1500) % 2) == 1;
            if (down_left > 0) begin
                link_up = 1'b0;
                down_left--;
            end else if ($urandom_range(0, 499) == 0) begin
                link_up = 1'b0;
                down_left = $urandom_range(0, 2);
            end else begin
                link_up = 1'b1;
            end
            dllp_ready = ($urandom_range(0, 3) != 0);
            set_rx(quiet ? ($urandom_range(0, 199) == 0) : ($urandom_range(0, 7) == 0),
                   1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : VC);
            rx_updatefc_valid = quiet ? 1'b0 : ($urandom_range(0, 199) == 0);
            p_hdr_fc = 8'($urandom);   np_hdr_fc = 8'($urandom);   cpl_hdr_fc = 8'($urandom);
            p_data_fc = 12'($urandom); np_data_fc = 12'($urandom); cpl_data_fc = 12'($urandom);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
